// File: rtl/voting_pkg.sv
// Shared definitions for the voting machine result path.
// Holds the tally FSM state encoding, candidate/count widths, the result
// frame byte positions, the default frame header and the frame checksum helper.
package voting_pkg;

    localparam int NUM_CAND  = 4;
    localparam int COUNT_W   = 8;
    localparam int TOTAL_W   = 10;
    localparam int FRAME_LEN = 7;

    // Byte positions inside the 7-byte result frame.
    localparam logic [2:0] BYTE_HDR    = 3'd0;
    localparam logic [2:0] BYTE_CAND0  = 3'd1;
    localparam logic [2:0] BYTE_RESULT = 3'd5;
    localparam logic [2:0] BYTE_CHK    = 3'd6;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } tally_state_t;

    // XOR of the six frame bytes that precede the checksum byte.
    function automatic logic [7:0] xor_checksum(input logic [5:0][7:0] body);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 6; i++) begin
            acc = acc ^ body[i];
        end
        return acc;
    endfunction

endpackage

// File: rtl/result_tallier_if.sv
// Byte stream carrying the result frame to a display or UART stage.
//   out_valid : a frame byte is present (driven by master)
//   out_data  : frame byte, stable while out_valid is high (driven by master)
//   out_ready : sink accepts the byte (driven by slave)
interface result_tallier_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/result_tallier_framer.sv
// result_framer: holds the 7-byte result frame and presents it one byte at a
// time on a valid/ready stage.
//   clock, reset   : clock and asynchronous active-low reset
//   load           : capture the frame fields and start presenting byte 0
//   counts, tie,
//   winner         : frame fields (header and checksum are generated here)
//   out_ready      : sink handshake
//   out_valid/data : registered byte stage
//   last_accepted  : high in the cycle the checksum byte transfers
module result_framer
    import voting_pkg::*;
#(
    parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               load,
    input  logic [NUM_CAND-1:0][COUNT_W-1:0]   counts,
    input  logic                               tie,
    input  logic [1:0]                         winner,
    input  logic                               out_ready,
    output logic                               out_valid,
    output logic [7:0]                         out_data,
    output logic                               last_accepted
);

    logic [FRAME_LEN-1:0][7:0] frame_r;
    logic [FRAME_LEN-1:0][7:0] frame_s;
    logic [5:0][7:0]           body_s;
    logic [2:0]                idx_r;
    logic [2:0]                idx_nx_s;
    logic                      valid_r;
    logic [7:0]                data_r;
    logic                      xfer_s;

    // Assemble the frame contents and its checksum from the load fields.
    always_comb begin
        body_s              = '0;
        body_s[BYTE_HDR]    = HEADER;
        for (int i = 0; i < NUM_CAND; i++) begin
            body_s[int'(BYTE_CAND0) + i] = counts[i];
        end
        body_s[BYTE_RESULT] = {tie, 5'b00000, winner};
        frame_s             = '0;
        frame_s[5:0]        = body_s;
        frame_s[BYTE_CHK]   = xor_checksum(body_s);
    end

    assign xfer_s        = valid_r & out_ready;
    assign idx_nx_s      = idx_r + 3'd1;
    assign last_accepted = xfer_s & (idx_r == BYTE_CHK);
    assign out_valid     = valid_r;
    assign out_data      = data_r;

    // Frame storage, byte index and the registered valid/data stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_r <= '0;
            idx_r   <= 3'd0;
            valid_r <= 1'b0;
            data_r  <= 8'h00;
        end else if (load) begin
            frame_r <= frame_s;
            idx_r   <= BYTE_HDR;
            valid_r <= 1'b1;
            data_r  <= frame_s[BYTE_HDR];
        end else if (xfer_s) begin
            if (idx_r == BYTE_CHK) begin
                idx_r   <= 3'd0;
                valid_r <= 1'b0;
                data_r  <= 8'h00;
            end else begin
                idx_r   <= idx_nx_s;
                data_r  <= frame_r[idx_nx_s];
            end
        end
    end

endmodule

// File: rtl/result_tallier.sv
// result_tallier: on each close of voting (mode 0->1) snapshots the four vote
// counts, scans them one per cycle for winner / winner count / tie / total,
// then streams the 7-byte result frame through result_framer.
//   clock, reset            : clock and asynchronous active-low reset
//   mode                    : 0 voting, 1 result; rising edge starts a tally
//   cand1..4_vote_recvd     : live counts
//   busy, done              : tally in progress / one-cycle completion pulse
//   winner, winner_votes,
//   tie, total_votes        : results, held until the next scan completes
//   out_if                  : result frame byte stream (master side)
module result_tallier
    import voting_pkg::*;
#(
    parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mode,
    input  logic [COUNT_W-1:0]    cand1_vote_recvd,
    input  logic [COUNT_W-1:0]    cand2_vote_recvd,
    input  logic [COUNT_W-1:0]    cand3_vote_recvd,
    input  logic [COUNT_W-1:0]    cand4_vote_recvd,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            winner,
    output logic [COUNT_W-1:0]    winner_votes,
    output logic                  tie,
    output logic [TOTAL_W-1:0]    total_votes,
    result_tallier_if.master      out_if
);

    tally_state_t                      state_r;
    logic                              mode_d_r;
    logic                              start_s;
    logic [NUM_CAND-1:0][COUNT_W-1:0]  snap_r;
    logic [COUNT_W-1:0]                max_r;
    logic [1:0]                        win_r;
    logic                              tie_acc_r;
    logic [1:0]                        idx_r;
    logic [TOTAL_W-1:0]                sum_r;
    logic                              busy_r;
    logic                              done_r;
    logic [1:0]                        winner_r;
    logic [COUNT_W-1:0]                winner_votes_r;
    logic                              tie_r;
    logic [TOTAL_W-1:0]                total_r;

    logic [COUNT_W-1:0]                cand_s;
    logic [COUNT_W-1:0]                max_nx_s;
    logic [1:0]                        win_nx_s;
    logic                              tie_nx_s;
    logic [TOTAL_W-1:0]                sum_nx_s;
    logic                              load_s;
    logic                              last_s;
    logic                              fr_valid_s;
    logic [7:0]                        fr_data_s;

    assign start_s = mode & ~mode_d_r;

    // Previous mode value for rising-edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_d_r <= 1'b0;
        end else begin
            mode_d_r <= mode;
        end
    end

    // One scan step: strict greater-than keeps the lowest index on equality.
    always_comb begin
        cand_s   = snap_r[idx_r];
        max_nx_s = max_r;
        win_nx_s = win_r;
        tie_nx_s = tie_acc_r;
        if (cand_s > max_r) begin
            max_nx_s = cand_s;
            win_nx_s = idx_r;
            tie_nx_s = 1'b0;
        end else if (cand_s == max_r) begin
            tie_nx_s = 1'b1;
        end else begin
            tie_nx_s = tie_acc_r;
        end
        sum_nx_s = sum_r + {2'b00, cand_s};
        load_s   = (state_r == SCAN) && (idx_r == 2'd3);
    end

    // Tally FSM: snapshot, scan datapath, result registers and status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            snap_r         <= '0;
            max_r          <= '0;
            win_r          <= 2'd0;
            tie_acc_r      <= 1'b0;
            idx_r          <= 2'd0;
            sum_r          <= '0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            winner_r       <= 2'd0;
            winner_votes_r <= '0;
            tie_r          <= 1'b0;
            total_r        <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start_s) begin
                        snap_r    <= {cand4_vote_recvd, cand3_vote_recvd,
                                      cand2_vote_recvd, cand1_vote_recvd};
                        max_r     <= cand1_vote_recvd;
                        win_r     <= 2'd0;
                        tie_acc_r <= 1'b0;
                        idx_r     <= 2'd1;
                        sum_r     <= {2'b00, cand1_vote_recvd};
                        busy_r    <= 1'b1;
                        state_r   <= SCAN;
                    end
                end
                SCAN: begin
                    max_r     <= max_nx_s;
                    win_r     <= win_nx_s;
                    tie_acc_r <= tie_nx_s;
                    sum_r     <= sum_nx_s;
                    idx_r     <= idx_r + 2'd1;
                    if (idx_r == 2'd3) begin
                        winner_r       <= win_nx_s;
                        winner_votes_r <= max_nx_s;
                        tie_r          <= tie_nx_s;
                        total_r        <= sum_nx_s;
                        state_r        <= SEND;
                    end
                end
                SEND: begin
                    if (last_s) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    result_framer #(.HEADER(HEADER)) u_framer (
        .clock         (clock),
        .reset         (reset),
        .load          (load_s),
        .counts        (snap_r),
        .tie           (tie_nx_s),
        .winner        (win_nx_s),
        .out_ready     (out_if.out_ready),
        .out_valid     (fr_valid_s),
        .out_data      (fr_data_s),
        .last_accepted (last_s)
    );

    assign out_if.out_valid = fr_valid_s;
    assign out_if.out_data  = fr_data_s;
    assign busy             = busy_r;
    assign done             = done_r;
    assign winner           = winner_r;
    assign winner_votes     = winner_votes_r;
    assign tie              = tie_r;
    assign total_votes      = total_r;

endmodule

// File: doc/result_tallier.md
# result_tallier

Downstream consumer of the four 8-bit vote counters in the voting machine. When voting closes (the `mode` input rises from 0 to 1), the block does the following:
- snapshots the counts;
- scans them sequentially to find the winner, the winning count, a tie flag and the total;
- streams a 7-byte result frame over a valid/ready byte interface for a display or UART stage.

Results are held until the next close of voting.

## Interface
Parameters:
- `HEADER`, default `8'hA5`: first byte of every frame.

Ports:
- `clock`, input, 1: single clock for the whole block.
- `reset`, input, 1: asynchronous, active-low reset.
- `mode`, input, 1: voting mode. 0 means voting, 1 means result. A rising edge starts a tally.
- `cand1_vote_recvd` .. `cand4_vote_recvd`, input, 8 each: live counts.
- `busy`, output, 1: high from the cycle after the start through the last byte accepted.
- `done`, output, 1: one-cycle pulse after the final frame byte is accepted.
- `winner`, output, 2: index of the winner, 0..3 (candidate 1 maps to index 0).
- `winner_votes`, output, 8: count of the winner.
- `tie`, output, 1: high when at least one other candidate equals `winner_votes`.
- `total_votes`, output, 10: sum of the four counts.
- `out_valid`, output, 1: a frame byte is present.
- `out_ready`, input, 1: the sink accepts the byte.
- `out_data`, output, 8: frame byte.

## Operation
- Start detection: the registered `mode_d` flop resets to 0.
  - `start = mode & ~mode_d`.
  - If `mode` is high at reset release, a start fires on the first clock.
- FSM states are `IDLE`, `SCAN`, `SEND` and `DONE`.
- `IDLE`:
  - On `start`, latch all four counts into `snap[0..3]`.
  - Set `max = snap[0]`, `win = 0`, `tie = 0`, `idx = 1`.
  - Go to `SCAN`.
- `SCAN`: one candidate per cycle, for `idx` 1..3.
  - If `snap[idx] > max`: set `max = snap[idx]`, `win = idx`, `tie = 0`.
  - Else if `snap[idx] == max`: set `tie = 1`.
  - Strict greater-than gives the lowest index on equality.
  - Accumulate the total in 10 bits, which cannot overflow (max 1020).
  - After `idx` 3, register the results to the outputs, load the frame, and go to `SEND`.
- All-zero counts give `winner` 0, `winner_votes` 0, `tie` 1.
- `SEND`: bytes go out in this order:
  - `HEADER`
  - `snap[0]`, `snap[1]`, `snap[2]`, `snap[3]`
  - `{tie, 5'b0, winner}`
  - `chk`, which is the XOR of bytes 0..5.
- Handshake in `SEND`:
  - A byte transfers on `out_valid & out_ready`.
  - `out_valid` stays high and `out_data` stays stable until the byte transfers.
  - After byte 6 transfers, go to `DONE`.
- `DONE`: pulse `done` and return to `IDLE`.
- `start` is ignored outside `IDLE`. Count changes after the snapshot do not affect the frame in flight.
- `winner`, `winner_votes`, `tie` and `total_votes` hold their values until the next tally completes `SCAN`.
- Reset at any time, including mid-`SEND`:
  - All outputs go to 0 immediately: `out_valid` = 0, `out_data` = 0, `busy` = 0, `done` = 0, and all result outputs 0.
  - The FSM returns to `IDLE` and the frame is abandoned.

## Timing
- `start` seen in cycle T: the snapshot is taken at the T edge, and `busy` = 1 from T+1.
- `SCAN` occupies T+1..T+3.
- Result outputs update, and `out_valid` rises with `HEADER`, at T+4.
- With `out_ready` held high, bytes transfer at T+4..T+10.
- `done` is high in T+11, `busy` falls in T+11, and the FSM is back in `IDLE` at T+12.
- Each cycle of `out_ready` low stretches the completion by exactly one cycle.
- Minimum spacing between tallies: `mode` must fall and rise again. A start is possible in T+12.

## Structure
- Shared package `voting_pkg` holds:
  - the state enum (`IDLE`/`SCAN`/`SEND`/`DONE`);
  - `NUM_CAND` = 4 and `COUNT_W` = 8;
  - the frame byte-index constants and the default `HEADER`.
- Sub-module `result_framer`:
  - 7-byte frame register, 3-bit byte index, valid/ready output stage and XOR checksum;
  - inputs: a load strobe plus the frame fields;
  - output: a last-accepted pulse.
- The top level holds the edge detect, the snapshot, the scan datapath and the FSM.

## Test plan
- Counts 3, 7, 2, 7, `mode` rises, `out_ready` = 1:
  - `winner` = 1, `winner_votes` = 7, `tie` = 1, `total_votes` = 19.
  - Frame A5 03 07 02 07 81 25; `done` at T+11.
- Counts 10, 4, 250, 9:
  - `winner` = 2, `winner_votes` = 250, `tie` = 0, `total_votes` = 273.
  - Frame A5 0A 04 FA 09 02 5A.
- All counts 0: `winner` = 0, `tie` = 1, `total_votes` = 0, frame A5 00 00 00 00 80 25.
- All counts 255: `winner` = 0, `tie` = 1, `total_votes` = 1020, frame ends FF 80 25.
- Backpressure, using the counts 3, 7, 2, 7 frame:
  - Hold `out_ready` = 0 for 5 cycles while byte 2 (07) is presented.
  - `out_data` stays stable at 07 with `out_valid` high; `done` slips to T+16.
  - Counts changed during `SEND` do not alter the frame.
- Robustness:
  - Toggle `mode` 1→0→1 during `SEND`: no restart, frame completes unchanged.
  - Assert `reset` low mid-`SEND`: `out_valid`, `busy` and all results go to 0 immediately.
  - After release with `mode` = 1, a fresh tally starts on the first clock.
